// File: rtl/line_ctl_pkg.sv
// Shared codes for the line tracker controller: motor/wheel encodings,
// one-hot state values and IR sensor polarity.
package line_ctl_pkg;

   localparam logic [1:0] MOTOR_STOP  = 2'b00;
   localparam logic [1:0] MOTOR_FWD   = 2'b01;
   localparam logic [1:0] MOTOR_BACK  = 2'b10;
   localparam logic [1:0] MOTOR_BRAKE = 2'b11;

   localparam logic [2:0] WHEEL_STRAIGHT    = 3'b000;
   localparam logic [2:0] WHEEL_LEFT_SMALL  = 3'b001;
   localparam logic [2:0] WHEEL_LEFT_BIG    = 3'b011;
   localparam logic [2:0] WHEEL_RIGHT_SMALL = 3'b101;
   localparam logic [2:0] WHEEL_RIGHT_BIG   = 3'b111;

   localparam logic IR_WHITE = 1'b0;
   localparam logic IR_BLACK = 1'b1;

   typedef enum logic [5:0] {
      ST_STOP    = 6'b000001,
      ST_TRACK   = 6'b000010,
      ST_BRAKE   = 6'b000100,
      ST_FWD     = 6'b001000,
      ST_BACK    = 6'b010000,
      ST_REVERSE = 6'b100000
   } state_e;

endpackage

// File: rtl/line_tracker_ctl_if.sv
// Core/driver-side bundle of the line tracker controller: sensors and mode
// enables in, steering/motor commands and status flags out.
interface line_tracker_ctl_if #(
   parameter int unsigned N_IR = 4
);
   logic [N_IR-1:0] ir;
   logic            en_tracking;
   logic            en_uturn;
   logic            en_brake;
   logic            en_reverse;
   logic [2:0]      front_wheel;
   logic [1:0]      motor;
   logic            end_of_track;
   logic            line_lost;
   logic            uturn_finished;
   logic            brake_finished;
   logic            reverse_finished;
   logic            uturn_fault;

   modport master (
      output ir, en_tracking, en_uturn, en_brake, en_reverse,
      input  front_wheel, motor, end_of_track, line_lost,
             uturn_finished, brake_finished, reverse_finished, uturn_fault
   );

   modport slave (
      input  ir, en_tracking, en_uturn, en_brake, en_reverse,
      output front_wheel, motor, end_of_track, line_lost,
             uturn_finished, brake_finished, reverse_finished, uturn_fault
   );
endinterface

// File: rtl/steer_decoder.sv
// Proportional steering: left-half minus right-half black count mapped onto
// five wheel positions (line drifting left means steer right).
module steer_decoder
   import line_ctl_pkg::*;
#(
   parameter int unsigned N_IR = 4
) (
   input  logic [N_IR-1:0] ir,
   output logic [2:0]      wheel_c
);

   localparam int unsigned HALF = N_IR / 2;
   localparam int unsigned PW   = $clog2(HALF + 1);
   localparam int unsigned DW   = PW + 1;

   localparam logic signed [DW-1:0] D_P2 = DW'(2);
   localparam logic signed [DW-1:0] D_P1 = DW'(1);
   localparam logic signed [DW-1:0] D_Z  = '0;
   localparam logic signed [DW-1:0] D_M1 = '1;

   logic [PW-1:0]        l_cnt;
   logic [PW-1:0]        r_cnt;
   logic signed [DW-1:0] diff;

   always_comb begin
      l_cnt   = '0;
      r_cnt   = '0;
      wheel_c = WHEEL_STRAIGHT;
      for (int unsigned i = 0; i < HALF; i++) begin
         l_cnt = l_cnt + PW'(ir[HALF + i]);
         r_cnt = r_cnt + PW'(ir[i]);
      end
      diff = $signed({1'b0, l_cnt}) - $signed({1'b0, r_cnt});
      if (diff >= D_P2)      wheel_c = WHEEL_RIGHT_BIG;
      else if (diff == D_P1) wheel_c = WHEEL_RIGHT_SMALL;
      else if (diff == D_Z)  wheel_c = WHEEL_STRAIGHT;
      else if (diff == D_M1) wheel_c = WHEEL_LEFT_SMALL;
      else                   wheel_c = WHEEL_LEFT_BIG;
   end

endmodule

// File: rtl/line_tracker_ctl.sv
// Line tracking / u-turn / brake / reverse controller between Core and the
// servo/motor drivers. Optional TRACK_SLOW_EN pulses the motor on big steer.
module line_tracker_ctl
   import line_ctl_pkg::*;
#(
   parameter int unsigned N_IR        = 4,
   parameter int unsigned CNT_W       = 20,
   parameter int unsigned TURN_DELAY  = 500000,
   parameter int unsigned DRIVE_DELAY = 800000,
   parameter int unsigned BRAKE_TIME  = 1000000,
   parameter int unsigned LOST_TIME   = 300000,
   parameter int unsigned MAX_SWINGS  = 8
`ifdef TRACK_SLOW_EN
   ,
   parameter int unsigned SLOW_HALF   = 2000
`endif
) (
   input  logic               clkus,
   input  logic               rst,
   line_tracker_ctl_if.slave  bus
);

   localparam int unsigned IN_HI = N_IR / 2;
   localparam int unsigned IN_LO = N_IR / 2 - 1;
   localparam int unsigned SW_W  = $clog2(MAX_SWINGS + 1);

   state_e             state_q, state_d;
   logic [2:0]         front_wheel_q, front_wheel_d;
   logic [1:0]         motor_q, motor_d;
   logic               eot_q, eot_d;
   logic               lost_q, lost_d;
   logic               ufin_q, ufin_d;
   logic               bfin_q, bfin_d;
   logic               rfin_q, rfin_d;
   logic               ufault_q, ufault_d;
   logic [CNT_W-1:0]   leg_cnt_q, leg_cnt_d;
   logic [CNT_W-1:0]   brake_cnt_q, brake_cnt_d;
   logic [CNT_W-1:0]   lost_cnt_q, lost_cnt_d;
   logic [SW_W-1:0]    swing_cnt_q, swing_cnt_d;
   logic               arm_q, arm_d;
`ifdef TRACK_SLOW_EN
   logic [CNT_W-1:0]   slow_cnt_q, slow_cnt_d;
   logic               slow_ph_q, slow_ph_d;
`endif

   logic [N_IR-1:0]    ir;
   logic [2:0]         steer_c;
   logic               all_white_c;
   logic               all_black_c;
   logic               in_white_c;
   logic               in_black_c;
   logic               in_any_black_c;

   assign ir             = bus.ir;
   assign all_white_c    = (ir == {N_IR{IR_WHITE}});
   assign all_black_c    = (ir == {N_IR{IR_BLACK}});
   assign in_white_c     = (ir[IN_HI] == IR_WHITE) && (ir[IN_LO] == IR_WHITE);
   assign in_black_c     = (ir[IN_HI] == IR_BLACK) && (ir[IN_LO] == IR_BLACK);
   assign in_any_black_c = (ir[IN_HI] == IR_BLACK) || (ir[IN_LO] == IR_BLACK);

   steer_decoder #(
      .N_IR (N_IR)
   ) u_steer (
      .ir      (ir),
      .wheel_c (steer_c)
   );

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Next state, counters and registered outputs; outputs follow the next state.
   always_comb begin
      state_d       = state_q;
      front_wheel_d = front_wheel_q;
      motor_d       = motor_q;
      eot_d         = eot_q;
      lost_d        = lost_q;
      ufin_d        = ufin_q;
      bfin_d        = bfin_q;
      rfin_d        = rfin_q;
      ufault_d      = ufault_q;
      leg_cnt_d     = leg_cnt_q;
      brake_cnt_d   = brake_cnt_q;
      lost_cnt_d    = lost_cnt_q;
      swing_cnt_d   = swing_cnt_q;
      arm_d         = arm_q;
`ifdef TRACK_SLOW_EN
      slow_cnt_d    = '0;
      slow_ph_d     = 1'b0;
`endif

      unique case (state_q)
         ST_STOP: begin
            if (!bus.en_uturn) begin
               ufin_d   = 1'b0;
               ufault_d = 1'b0;
            end
            if (!bus.en_brake)   bfin_d = 1'b0;
            if (!bus.en_reverse) rfin_d = 1'b0;
            if (bus.en_tracking) begin
               state_d = ST_TRACK;
            end else if (bus.en_uturn && !ufin_q) begin
               state_d     = ST_FWD;
               leg_cnt_d   = '0;
               swing_cnt_d = '0;
               arm_d       = 1'b0;
            end else if (bus.en_brake && !bfin_q) begin
               state_d     = ST_BRAKE;
               brake_cnt_d = '0;
            end else if (bus.en_reverse && !rfin_q) begin
               state_d = ST_REVERSE;
            end
         end
         ST_TRACK: begin
            if (!bus.en_tracking) state_d = ST_STOP;
         end
         ST_BRAKE: begin
            if (brake_cnt_q >= CNT_W'(BRAKE_TIME - 1)) begin
               state_d = ST_STOP;
               bfin_d  = 1'b1;
            end else begin
               brake_cnt_d = sat_inc(brake_cnt_q);
            end
         end
         ST_FWD, ST_BACK: begin
            if (all_white_c) begin
               state_d = ST_STOP;
               ufin_d  = 1'b1;
            end else if (arm_q && in_any_black_c) begin
               // A switch that would reach the swing limit ends the manoeuvre instead
               if ((swing_cnt_q + SW_W'(1)) == SW_W'(MAX_SWINGS)) begin
                  state_d  = ST_STOP;
                  ufin_d   = 1'b1;
                  ufault_d = 1'b1;
               end else begin
                  state_d     = (state_q == ST_FWD) ? ST_BACK : ST_FWD;
                  leg_cnt_d   = '0;
                  arm_d       = 1'b0;
                  swing_cnt_d = swing_cnt_q + SW_W'(1);
               end
            end else begin
               leg_cnt_d = sat_inc(leg_cnt_q);
               if (in_white_c) arm_d = 1'b1;
            end
         end
         ST_REVERSE: begin
            if (in_black_c) begin
               state_d = ST_STOP;
               rfin_d  = 1'b1;
            end
         end
         default: state_d = ST_STOP;
      endcase

      unique case (state_d)
         ST_TRACK: begin
            front_wheel_d = steer_c;
            lost_cnt_d    = all_white_c
                            ? ((lost_cnt_q >= CNT_W'(LOST_TIME)) ? lost_cnt_q
                                                                 : lost_cnt_q + CNT_W'(1))
                            : '0;
            eot_d         = eot_q | all_black_c;
            lost_d        = lost_q | (lost_cnt_d >= CNT_W'(LOST_TIME));
            motor_d       = MOTOR_FWD;
`ifdef TRACK_SLOW_EN
            // Phase counter runs only while steering hard and the line is usable
            if (((steer_c == WHEEL_LEFT_BIG) || (steer_c == WHEEL_RIGHT_BIG))
                && !eot_d && !lost_d) begin
               if (slow_cnt_q >= CNT_W'(SLOW_HALF - 1)) begin
                  slow_cnt_d = '0;
                  slow_ph_d  = ~slow_ph_q;
               end else begin
                  slow_cnt_d = slow_cnt_q + CNT_W'(1);
                  slow_ph_d  = slow_ph_q;
               end
               motor_d = slow_ph_q ? MOTOR_STOP : MOTOR_FWD;
            end
`endif
            if (eot_d || lost_d) motor_d = MOTOR_STOP;
         end
         ST_BRAKE: begin
            front_wheel_d = WHEEL_STRAIGHT;
            motor_d       = MOTOR_BRAKE;
         end
         ST_FWD: begin
            front_wheel_d = (leg_cnt_d >= CNT_W'(TURN_DELAY)) ? WHEEL_LEFT_BIG : front_wheel_q;
            motor_d       = (leg_cnt_d >= CNT_W'(DRIVE_DELAY)) ? MOTOR_FWD : MOTOR_STOP;
         end
         ST_BACK: begin
            front_wheel_d = (leg_cnt_d >= CNT_W'(TURN_DELAY)) ? WHEEL_RIGHT_BIG : front_wheel_q;
            motor_d       = (leg_cnt_d >= CNT_W'(DRIVE_DELAY)) ? MOTOR_BACK : MOTOR_STOP;
         end
         ST_REVERSE: begin
            front_wheel_d = WHEEL_STRAIGHT;
            motor_d       = MOTOR_BACK;
         end
         default: begin
            front_wheel_d = WHEEL_STRAIGHT;
            motor_d       = MOTOR_STOP;
            eot_d         = 1'b0;
            lost_d        = 1'b0;
            lost_cnt_d    = '0;
            brake_cnt_d   = '0;
            leg_cnt_d     = '0;
            arm_d         = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clkus or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_STOP;
         front_wheel_q <= '0;
         motor_q       <= '0;
         eot_q         <= 1'b0;
         lost_q        <= 1'b0;
         ufin_q        <= 1'b0;
         bfin_q        <= 1'b0;
         rfin_q        <= 1'b0;
         ufault_q      <= 1'b0;
         leg_cnt_q     <= '0;
         brake_cnt_q   <= '0;
         lost_cnt_q    <= '0;
         swing_cnt_q   <= '0;
         arm_q         <= 1'b0;
`ifdef TRACK_SLOW_EN
         slow_cnt_q    <= '0;
         slow_ph_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         front_wheel_q <= front_wheel_d;
         motor_q       <= motor_d;
         eot_q         <= eot_d;
         lost_q        <= lost_d;
         ufin_q        <= ufin_d;
         bfin_q        <= bfin_d;
         rfin_q        <= rfin_d;
         ufault_q      <= ufault_d;
         leg_cnt_q     <= leg_cnt_d;
         brake_cnt_q   <= brake_cnt_d;
         lost_cnt_q    <= lost_cnt_d;
         swing_cnt_q   <= swing_cnt_d;
         arm_q         <= arm_d;
`ifdef TRACK_SLOW_EN
         slow_cnt_q    <= slow_cnt_d;
         slow_ph_q     <= slow_ph_d;
`endif
      end
   end

   assign bus.front_wheel      = front_wheel_q;
   assign bus.motor            = motor_q;
   assign bus.end_of_track     = eot_q;
   assign bus.line_lost        = lost_q;
   assign bus.uturn_finished   = ufin_q;
   assign bus.brake_finished   = bfin_q;
   assign bus.reverse_finished = rfin_q;
   assign bus.uturn_fault      = ufault_q;

endmodule

// File: tb/tb_line_tracker_ctl.sv
// Self-checking bench for line_tracker_ctl (N_IR=6, short delays): steering
// table plus hand-written lost-line, brake, u-turn and reset sequences.
module tb_line_tracker_ctl;

   localparam int unsigned N_IR = 6;

   typedef struct packed {
      logic [5:0] ir;
      logic [3:0] en;     // {tracking, uturn, brake, reverse}
      logic [2:0] wheel;
      logic [1:0] motor;
      logic [5:0] flags;  // {eot, lost, ufin, bfin, rfin, ufault}
   } vec_t;

   typedef struct {
      int          tag;
      logic [10:0] exp;
   } sb_t;

   logic        clkus = 1'b0;
   logic        rst   = 1'b0;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          step_no = 0;
   string       phase   = "init";
   sb_t         sb_q[$];
   logic [10:0] outs;

   always #5 clkus = ~clkus;

   line_tracker_ctl_if #(.N_IR(N_IR)) bus ();

   line_tracker_ctl #(
      .N_IR        (N_IR),
      .CNT_W       (20),
      .TURN_DELAY  (5),
      .DRIVE_DELAY (8),
      .BRAKE_TIME  (10),
      .LOST_TIME   (6),
      .MAX_SWINGS  (3)
   ) dut (
      .clkus (clkus),
      .rst   (rst),
      .bus   (bus)
   );

   assign outs = {bus.front_wheel, bus.motor, bus.end_of_track, bus.line_lost,
                  bus.uturn_finished, bus.brake_finished, bus.reverse_finished,
                  bus.uturn_fault};

   task automatic check_now(input string nm, input logic [10:0] exp);
      n_tests++;
      if (outs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", nm, outs, exp);
      end
   endtask

   task automatic pop_check();
      sb_t s;
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, got %b want <entry>", phase, outs);
      end else begin
         s = sb_q.pop_front();
         if (outs !== s.exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %b want %b", phase, s.tag, outs, s.exp);
         end
      end
   endtask

   task automatic apply(input logic [5:0] i, input logic [3:0] e, input logic [2:0] w,
                        input logic [1:0] m, input logic [5:0] f);
      sb_t s;
      @(negedge clkus);
      bus.ir = i;
      {bus.en_tracking, bus.en_uturn, bus.en_brake, bus.en_reverse} = e;
      s.tag = step_no;
      s.exp = {w, m, f};
      sb_q.push_back(s);
      step_no++;
      @(posedge clkus);
      #1;
      pop_check();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      vec_t steer_tbl [6];
      steer_tbl[0] = '{6'b110000, 4'b1000, 3'b111, 2'b01, 6'b000000};
      steer_tbl[1] = '{6'b010000, 4'b1000, 3'b101, 2'b01, 6'b000000};
      steer_tbl[2] = '{6'b001100, 4'b1000, 3'b000, 2'b01, 6'b000000};
      steer_tbl[3] = '{6'b000011, 4'b1000, 3'b011, 2'b01, 6'b000000};
      steer_tbl[4] = '{6'b111111, 4'b1000, 3'b000, 2'b00, 6'b100000};
      steer_tbl[5] = '{6'b001100, 4'b1000, 3'b000, 2'b00, 6'b100000};

      bus.ir = '0;
      {bus.en_tracking, bus.en_uturn, bus.en_brake, bus.en_reverse} = 4'b0000;
      repeat (2) @(negedge clkus);
      check_now("reset", 11'b0);
      rst = 1'b1;

      phase = "steer";
      for (int k = 0; k < 6; k++)
         apply(steer_tbl[k].ir, steer_tbl[k].en, steer_tbl[k].wheel,
               steer_tbl[k].motor, steer_tbl[k].flags);
      phase = "track_exit";
      apply(6'b001100, 4'b0000, 3'b000, 2'b00, 6'b000000);

      phase = "priority";
      apply(6'b001100, 4'b1100, 3'b000, 2'b01, 6'b000000);
      apply(6'b001100, 4'b0000, 3'b000, 2'b00, 6'b000000);

      phase = "lost";
      apply(6'b001100, 4'b1000, 3'b000, 2'b01, 6'b000000);
      repeat (3) apply(6'b000000, 4'b1000, 3'b000, 2'b01, 6'b000000);
      apply(6'b000100, 4'b1000, 3'b001, 2'b01, 6'b000000);
      repeat (5) apply(6'b000000, 4'b1000, 3'b000, 2'b01, 6'b000000);
      apply(6'b000000, 4'b1000, 3'b000, 2'b00, 6'b010000);
      apply(6'b001100, 4'b1000, 3'b000, 2'b00, 6'b010000);
      apply(6'b001100, 4'b0000, 3'b000, 2'b00, 6'b000000);

      phase = "brake";
      for (int k = 0; k < 10; k++)
         apply(6'b001100, (k >= 3 && k <= 5) ? 4'b1000 : 4'b0010, 3'b000, 2'b11, 6'b000000);
      apply(6'b001100, 4'b0010, 3'b000, 2'b00, 6'b000100);
      apply(6'b001100, 4'b0010, 3'b000, 2'b00, 6'b000100);
      apply(6'b001100, 4'b0000, 3'b000, 2'b00, 6'b000000);

      phase = "uturn";
      for (int k = 0; k < 9; k++)
         apply(6'b001100, (k == 2) ? 4'b0000 : 4'b0100,
               (k >= 5) ? 3'b011 : 3'b000, (k >= 8) ? 2'b01 : 2'b00, 6'b000000);
      apply(6'b100001, 4'b0100, 3'b011, 2'b01, 6'b000000);
      for (int k = 0; k < 9; k++)
         apply(6'b001000, 4'b0100, (k >= 5) ? 3'b111 : 3'b011,
               (k >= 8) ? 2'b10 : 2'b00, 6'b000000);
      apply(6'b100001, 4'b0100, 3'b111, 2'b10, 6'b000000);
      for (int k = 0; k < 5; k++)
         apply(6'b000100, 4'b0100, 3'b111, 2'b00, 6'b000000);
      apply(6'b100001, 4'b0100, 3'b011, 2'b00, 6'b000000);

      phase = "swing_limit";
      apply(6'b001100, 4'b0100, 3'b000, 2'b00, 6'b001001);
      repeat (2) apply(6'b001100, 4'b0100, 3'b000, 2'b00, 6'b001001);
      apply(6'b001100, 4'b0000, 3'b000, 2'b00, 6'b000000);

      phase = "uturn_white";
      apply(6'b001100, 4'b0100, 3'b000, 2'b00, 6'b000000);
      apply(6'b000000, 4'b0100, 3'b000, 2'b00, 6'b001000);
      apply(6'b000000, 4'b0000, 3'b000, 2'b00, 6'b000000);

      phase = "reverse";
      apply(6'b000000, 4'b0001, 3'b000, 2'b10, 6'b000000);
      apply(6'b001000, 4'b0001, 3'b000, 2'b10, 6'b000000);
      @(negedge clkus);
      #2 rst = 1'b0;
      #1 check_now("async_reset", 11'b0);
      @(negedge clkus);
      {bus.en_tracking, bus.en_uturn, bus.en_brake, bus.en_reverse} = 4'b0000;
      rst = 1'b1;
      apply(6'b001000, 4'b0001, 3'b000, 2'b10, 6'b000000);
      apply(6'b001100, 4'b0001, 3'b000, 2'b00, 6'b000010);
      apply(6'b001100, 4'b0000, 3'b000, 2'b00, 6'b000000);

      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d left want 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
